// File: rtl/upc_monitor_pkg.sv
// Shared types and helpers for the HLS loop/module activity monitors.
// Counters of any width up to MaxCntW use sat_inc for wrap-free increments.
package upc_monitor_pkg;

    localparam int unsigned MaxCntW = 64;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFrozen
    } mon_state_e;

    // Increment that sticks at the all-ones value of a width-bit counter.
    function automatic logic [MaxCntW-1:0] sat_inc(input logic [MaxCntW-1:0] value,
                                                   input int unsigned        width);
        logic [MaxCntW-1:0] ceiling;
        ceiling = (width >= MaxCntW) ? '1 : ((MaxCntW'(1) << width) - MaxCntW'(1));
        return (value >= ceiling) ? value : value + MaxCntW'(1);
    endfunction

endpackage

// File: rtl/nodf_module_tracker.sv
// Start/done handshake tracker: owns the IDLE/RUN/FROZEN state, invocation
// count, busy-cycle count and per-invocation latency. Reusable for non-loop blocks.
module nodf_module_tracker
    import upc_monitor_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             close_req,
    input  logic             finish,
    output logic             busy,
    output logic             done_pulse,
    output logic             frozen,
    output logic             start_ev,
    output logic             close_ev,
    output logic [CNT_W-1:0] invocation_count,
    output logic [CNT_W-1:0] active_cycles,
    output logic [CNT_W-1:0] last_latency
);

    function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] v);
        return CNT_W'(sat_inc(MaxCntW'(v), CNT_W));
    endfunction

    mon_state_e       state_q, state_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] inv_q, inv_d;
    logic [CNT_W-1:0] act_q, act_d;
    logic [CNT_W-1:0] lat_q, lat_d;
    logic [CNT_W-1:0] last_lat_q, last_lat_d;

    always_comb begin
        state_d    = state_q;
        done_d     = 1'b0;
        inv_d      = inv_q;
        act_d      = act_q;
        lat_d      = lat_q;
        last_lat_d = last_lat_q;
        start_ev   = 1'b0;
        close_ev   = 1'b0;
        if (finish) begin
            state_d = StFrozen;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        start_ev = 1'b1;
                        state_d  = StRun;
                        inv_d    = inc(inv_q);
                        lat_d    = CNT_W'(1);
                    end
                end
                StRun: begin
                    act_d = inc(act_q);
                    lat_d = inc(lat_q);
                    if (close_req) begin
                        // Latency includes the closing cycle itself.
                        close_ev   = 1'b1;
                        done_d     = 1'b1;
                        last_lat_d = inc(lat_q);
                        if (start) begin
                            start_ev = 1'b1;
                            inv_d    = inc(inv_q);
                            lat_d    = CNT_W'(1);
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            done_q     <= 1'b0;
            inv_q      <= '0;
            act_q      <= '0;
            lat_q      <= '0;
            last_lat_q <= '0;
        end else begin
            state_q    <= state_d;
            done_q     <= done_d;
            inv_q      <= inv_d;
            act_q      <= act_d;
            lat_q      <= lat_d;
            last_lat_q <= last_lat_d;
        end
    end

    assign busy             = (state_q == StRun);
    assign frozen           = (state_q == StFrozen);
    assign done_pulse       = done_q;
    assign invocation_count = inv_q;
    assign active_cycles    = act_q;
    assign last_latency     = last_lat_q;

endmodule

// File: rtl/upc_loop_monitor.sv
// Non-intrusive monitor for one HLS pipelined loop: adds FSM state matching,
// iteration, and stall counting on top of the generic handshake tracker.
module upc_loop_monitor
    import upc_monitor_pkg::*;
#(
    parameter int unsigned STATE_W = 1,
    parameter int unsigned CNT_W   = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [STATE_W-1:0] cur_state,
    input  logic [STATE_W-1:0] iter_start_state,
    input  logic [STATE_W-1:0] iter_end_state,
    input  logic [STATE_W-1:0] quit_state,
    input  logic               iter_start_block,
    input  logic               iter_end_block,
    input  logic               quit_block,
    input  logic               iter_start_enable,
    input  logic               iter_end_enable,
    input  logic               quit_enable,
    input  logic               loop_start,
    input  logic               loop_ready,
    input  logic               loop_done,
    input  logic               loop_continue,
    input  logic               quit_at_end,
    input  logic               finish,
    output logic               busy,
    output logic               done_pulse,
    output logic               frozen,
    output logic [CNT_W-1:0]   invocation_count,
    output logic [CNT_W-1:0]   iter_start_count,
    output logic [CNT_W-1:0]   iter_end_count,
    output logic [CNT_W-1:0]   stall_count,
    output logic [CNT_W-1:0]   active_cycles,
    output logic [CNT_W-1:0]   last_latency,
    output logic [CNT_W-1:0]   last_iters
);

    function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] v);
        return CNT_W'(sat_inc(MaxCntW'(v), CNT_W));
    endfunction

    // loop_ready is informational only.
    logic unused_loop_ready;
    assign unused_loop_ready = loop_ready;

    logic match_start, match_end, match_quit;
    logic istart, iend, quit, stall, close_req;
    logic start_ev, close_ev;

    assign match_start = |(cur_state & iter_start_state);
    assign match_end   = |(cur_state & iter_end_state);
    assign match_quit  = |(cur_state & quit_state);

    assign istart    = busy & match_start & iter_start_enable & ~iter_start_block;
    assign iend      = busy & match_end & iter_end_enable & ~iter_end_block;
    assign quit      = busy & match_quit & quit_enable & ~quit_block;
    assign stall     = busy & match_start & iter_start_block;
    assign close_req = loop_continue & (quit_at_end ? loop_done : quit);

    nodf_module_tracker #(
        .CNT_W(CNT_W)
    ) u_tracker (
        .clock           (clock),
        .reset           (reset),
        .start           (loop_start),
        .close_req       (close_req),
        .finish          (finish),
        .busy            (busy),
        .done_pulse      (done_pulse),
        .frozen          (frozen),
        .start_ev        (start_ev),
        .close_ev        (close_ev),
        .invocation_count(invocation_count),
        .active_cycles   (active_cycles),
        .last_latency    (last_latency)
    );

    logic [CNT_W-1:0] istart_q, istart_d;
    logic [CNT_W-1:0] iend_q, iend_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] iter_q, iter_d;
    logic [CNT_W-1:0] last_iters_q, last_iters_d;
    logic [CNT_W-1:0] iter_cur;

    always_comb begin
        istart_d     = istart_q;
        iend_d       = iend_q;
        stall_d      = stall_q;
        iter_d       = iter_q;
        last_iters_d = last_iters_q;
        iter_cur     = iend ? inc(iter_q) : iter_q;
        if (!finish) begin
            if (istart) istart_d = inc(istart_q);
            if (iend)   iend_d   = inc(iend_q);
            if (stall)  stall_d  = inc(stall_q);
            iter_d = iter_cur;
        end
        // A same-cycle IEND belongs to the invocation being closed.
        if (close_ev) last_iters_d = iter_cur;
        if (start_ev) iter_d = '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            istart_q     <= '0;
            iend_q       <= '0;
            stall_q      <= '0;
            iter_q       <= '0;
            last_iters_q <= '0;
        end else begin
            istart_q     <= istart_d;
            iend_q       <= iend_d;
            stall_q      <= stall_d;
            iter_q       <= iter_d;
            last_iters_q <= last_iters_d;
        end
    end

    assign iter_start_count = istart_q;
    assign iter_end_count   = iend_q;
    assign stall_count      = stall_q;
    assign last_iters       = last_iters_q;

endmodule

// File: tb/tb_upc_loop_monitor.sv
// Self-checking bench for upc_loop_monitor: per-scenario tasks plus a
// scoreboard of expected (latency, iterations) pairs checked on done_pulse.
module tb_upc_loop_monitor;

    logic clock;
    logic reset;
    logic cur_state, iter_start_state, iter_end_state, quit_state;
    logic iter_start_block, iter_end_block, quit_block;
    logic iter_start_enable, iter_end_enable, quit_enable;
    logic loop_start, loop_ready, loop_done, loop_continue, quit_at_end, finish;

    logic        busy, done_pulse, frozen;
    logic [31:0] invocation_count, iter_start_count, iter_end_count, stall_count;
    logic [31:0] active_cycles, last_latency, last_iters;

    logic       s_busy, s_done_pulse, s_frozen;
    logic [3:0] s_invocation_count, s_iter_start_count, s_iter_end_count, s_stall_count;
    logic [3:0] s_active_cycles, s_last_latency, s_last_iters;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int lat;
        int iters;
    } close_t;
    close_t exp_q[$];

    upc_loop_monitor #(.STATE_W(1), .CNT_W(32)) dut (
        .clock(clock), .reset(reset), .cur_state(cur_state),
        .iter_start_state(iter_start_state), .iter_end_state(iter_end_state),
        .quit_state(quit_state), .iter_start_block(iter_start_block),
        .iter_end_block(iter_end_block), .quit_block(quit_block),
        .iter_start_enable(iter_start_enable), .iter_end_enable(iter_end_enable),
        .quit_enable(quit_enable), .loop_start(loop_start), .loop_ready(loop_ready),
        .loop_done(loop_done), .loop_continue(loop_continue), .quit_at_end(quit_at_end),
        .finish(finish), .busy(busy), .done_pulse(done_pulse), .frozen(frozen),
        .invocation_count(invocation_count), .iter_start_count(iter_start_count),
        .iter_end_count(iter_end_count), .stall_count(stall_count),
        .active_cycles(active_cycles), .last_latency(last_latency), .last_iters(last_iters)
    );

    upc_loop_monitor #(.STATE_W(1), .CNT_W(4)) dut_small (
        .clock(clock), .reset(reset), .cur_state(cur_state),
        .iter_start_state(iter_start_state), .iter_end_state(iter_end_state),
        .quit_state(quit_state), .iter_start_block(iter_start_block),
        .iter_end_block(iter_end_block), .quit_block(quit_block),
        .iter_start_enable(iter_start_enable), .iter_end_enable(iter_end_enable),
        .quit_enable(quit_enable), .loop_start(loop_start), .loop_ready(loop_ready),
        .loop_done(loop_done), .loop_continue(loop_continue), .quit_at_end(quit_at_end),
        .finish(finish), .busy(s_busy), .done_pulse(s_done_pulse), .frozen(s_frozen),
        .invocation_count(s_invocation_count), .iter_start_count(s_iter_start_count),
        .iter_end_count(s_iter_end_count), .stall_count(s_stall_count),
        .active_cycles(s_active_cycles), .last_latency(s_last_latency),
        .last_iters(s_last_iters)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Scoreboard consumer: every done_pulse must match the oldest expected close.
    always @(negedge clock) begin
        if (reset === 1'b0 && done_pulse === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_done: done_pulse=1 required no close pending");
            end else begin
                close_t e;
                e = exp_q.pop_front();
                if (last_latency !== e.lat || last_iters !== e.iters) begin
                    n_fail++;
                    $display("FAIL scoreboard_close: got lat=%0d iters=%0d required lat=%0d iters=%0d",
                             last_latency, last_iters, e.lat, e.iters);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_defaults();
        cur_state = 1'b1; iter_start_state = 1'b1; iter_end_state = 1'b1; quit_state = 1'b1;
        iter_start_block = 1'b0; iter_end_block = 1'b0; quit_block = 1'b0;
        iter_start_enable = 1'b1; iter_end_enable = 1'b1; quit_enable = 1'b1;
        loop_start = 1'b0; loop_ready = 1'b0; loop_done = 1'b0; loop_continue = 1'b1;
        quit_at_end = 1'b1; finish = 1'b0;
    endtask

    task automatic pulse_reset();
        apply_defaults();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_defaults();
        reset = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({busy, done_pulse, frozen} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags: got %b required 000", {busy, done_pulse, frozen});
        end
        n_checks++;
        if (invocation_count !== 0 || iter_end_count !== 0 || active_cycles !== 0) begin
            n_fail++; $display("FAIL reset_counts: got inv=%0d iend=%0d act=%0d required 0",
                               invocation_count, iter_end_count, active_cycles);
        end
        n_checks++;
        if (last_latency !== 0 || last_iters !== 0 || s_iter_end_count !== 0) begin
            n_fail++; $display("FAIL reset_last: got lat=%0d iters=%0d required 0",
                               last_latency, last_iters);
        end
        reset = 1'b0;
        // loop_done while idle must be ignored.
        loop_done = 1'b1;
        tick();
        loop_done = 1'b0;
        tick();
        n_checks++;
        if (busy !== 1'b0 || invocation_count !== 0 || last_latency !== 0) begin
            n_fail++; $display("FAIL idle_done_ignored: got busy=%b inv=%0d required 0 0",
                               busy, invocation_count);
        end
    endtask

    task automatic test_basic();
        pulse_reset();
        loop_start = 1'b1;
        tick();
        loop_start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || invocation_count !== 1) begin
            n_fail++; $display("FAIL basic_open: got busy=%b inv=%0d required 1 1",
                               busy, invocation_count);
        end
        exp_q.push_back('{lat: 6, iters: 5});
        repeat (4) tick();
        loop_done = 1'b1;
        tick();
        loop_done = 1'b0;
        n_checks++;
        if (done_pulse !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL basic_close: got done=%b busy=%b required 1 0",
                               done_pulse, busy);
        end
        tick();
        n_checks++;
        if (done_pulse !== 1'b0) begin
            n_fail++; $display("FAIL basic_pulse_width: got %b required 0", done_pulse);
        end
        n_checks++;
        if (iter_end_count !== 5 || iter_start_count !== 5 || active_cycles !== 5) begin
            n_fail++; $display("FAIL basic_counts: got iend=%0d istart=%0d act=%0d required 5 5 5",
                               iter_end_count, iter_start_count, active_cycles);
        end
    endtask

    task automatic test_stall();
        pulse_reset();
        loop_start = 1'b1;
        tick();
        loop_start = 1'b0;
        repeat (2) tick();
        iter_start_block = 1'b1;
        repeat (3) tick();
        iter_start_block = 1'b0;
        tick();
        exp_q.push_back('{lat: 8, iters: 7});
        loop_done = 1'b1;
        tick();
        loop_done = 1'b0;
        n_checks++;
        if (stall_count !== 3) begin
            n_fail++; $display("FAIL stall_count: got %0d required 3", stall_count);
        end
        n_checks++;
        if (iter_start_count !== 4 || iter_end_count !== 7) begin
            n_fail++; $display("FAIL stall_istart: got istart=%0d iend=%0d required 4 7",
                               iter_start_count, iter_end_count);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int busy_drops;
        busy_drops = 0;
        pulse_reset();
        loop_start = 1'b1;
        tick();
        loop_start = 1'b0;
        repeat (2) begin
            tick();
            if (busy !== 1'b1) busy_drops++;
        end
        exp_q.push_back('{lat: 4, iters: 3});
        exp_q.push_back('{lat: 5, iters: 4});
        loop_start = 1'b1;
        loop_done = 1'b1;
        tick();
        loop_start = 1'b0;
        loop_done = 1'b0;
        n_checks++;
        if (done_pulse !== 1'b1 || invocation_count !== 2) begin
            n_fail++; $display("FAIL b2b_reopen: got done=%b inv=%0d required 1 2",
                               done_pulse, invocation_count);
        end
        if (busy !== 1'b1) busy_drops++;
        repeat (3) begin
            tick();
            if (busy !== 1'b1) busy_drops++;
        end
        loop_done = 1'b1;
        tick();
        loop_done = 1'b0;
        n_checks++;
        if (busy_drops !== 0) begin
            n_fail++; $display("FAIL b2b_busy_continuous: got %0d drops required 0", busy_drops);
        end
        n_checks++;
        if (busy !== 1'b0 || last_iters !== 4) begin
            n_fail++; $display("FAIL b2b_second_close: got busy=%b iters=%0d required 0 4",
                               busy, last_iters);
        end
        tick();
    endtask

    task automatic test_quit();
        pulse_reset();
        quit_at_end = 1'b0;
        quit_enable = 1'b0;
        loop_start = 1'b1;
        tick();
        loop_start = 1'b0;
        loop_done = 1'b1;
        tick();
        loop_done = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || done_pulse !== 1'b0) begin
            n_fail++; $display("FAIL quit_done_ignored: got busy=%b done=%b required 1 0",
                               busy, done_pulse);
        end
        quit_enable = 1'b1;
        quit_block = 1'b1;
        tick();
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL quit_blocked: got busy=%b required 1", busy);
        end
        quit_block = 1'b0;
        exp_q.push_back('{lat: 4, iters: 3});
        tick();
        n_checks++;
        if (busy !== 1'b0 || last_latency !== 4) begin
            n_fail++; $display("FAIL quit_close: got busy=%b lat=%0d required 0 4",
                               busy, last_latency);
        end
        tick();
    endtask

    task automatic test_finish();
        int changed;
        changed = 0;
        pulse_reset();
        loop_start = 1'b1;
        tick();
        loop_start = 1'b0;
        repeat (2) tick();
        finish = 1'b1;
        tick();
        finish = 1'b0;
        n_checks++;
        if (frozen !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL finish_freeze: got frozen=%b busy=%b required 1 0",
                               frozen, busy);
        end
        repeat (6) begin
            loop_start = 1'($urandom_range(1));
            loop_done = 1'($urandom_range(1));
            iter_start_block = 1'($urandom_range(1));
            cur_state = 1'($urandom_range(1));
            tick();
            if (invocation_count !== 1 || active_cycles !== 2 || iter_start_count !== 2 ||
                iter_end_count !== 2 || stall_count !== 0 || frozen !== 1'b1 ||
                done_pulse !== 1'b0) changed++;
        end
        n_checks++;
        if (changed !== 0) begin
            n_fail++; $display("FAIL finish_hold: got %0d changed cycles required 0", changed);
        end
        // finish coinciding with a close: freeze wins, last_* untouched.
        pulse_reset();
        loop_start = 1'b1;
        tick();
        loop_start = 1'b0;
        tick();
        loop_done = 1'b1;
        finish = 1'b1;
        tick();
        loop_done = 1'b0;
        n_checks++;
        if (frozen !== 1'b1 || done_pulse !== 1'b0 || last_latency !== 0 || last_iters !== 0) begin
            n_fail++; $display("FAIL finish_beats_close: got frozen=%b done=%b lat=%0d required 1 0 0",
                               frozen, done_pulse, last_latency);
        end
        pulse_reset();
        n_checks++;
        if (frozen !== 1'b0 || busy !== 1'b0 || invocation_count !== 0 || active_cycles !== 0 ||
            iter_end_count !== 0) begin
            n_fail++; $display("FAIL finish_reset: got frozen=%b inv=%0d required 0 0",
                               frozen, invocation_count);
        end
    endtask

    task automatic test_saturation();
        pulse_reset();
        loop_start = 1'b1;
        tick();
        loop_start = 1'b0;
        repeat (19) tick();
        exp_q.push_back('{lat: 21, iters: 20});
        loop_done = 1'b1;
        tick();
        loop_done = 1'b0;
        n_checks++;
        if (iter_end_count !== 20) begin
            n_fail++; $display("FAIL sat_wide_iend: got %0d required 20", iter_end_count);
        end
        n_checks++;
        if (s_iter_end_count !== 4'd15 || s_active_cycles !== 4'd15) begin
            n_fail++; $display("FAIL sat_iend: got iend=%0d act=%0d required 15 15",
                               s_iter_end_count, s_active_cycles);
        end
        n_checks++;
        if (s_last_latency !== 4'd15 || s_last_iters !== 4'd15) begin
            n_fail++; $display("FAIL sat_last: got lat=%0d iters=%0d required 15 15",
                               s_last_latency, s_last_iters);
        end
        tick();
    endtask

    initial begin
        apply_defaults();
        reset = 1'b1;
        test_reset();
        test_basic();
        test_stall();
        test_back_to_back();
        test_quit();
        test_finish();
        test_saturation();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
